// File: rtl/bclk_training_ctrl.sv
// bclk_training_ctrl
// Fabric-side BCLK training controller for a DDR3 PHY lane.
// The controller steps the IOD input delay line one tap at a time and
// samples the deserialized BCLK pattern at every tap. It finds the stable
// eye between two pattern transitions, moves the delay line back to the
// eye centre, and then reports done or error.
//
// Ports:
//   fab_clk                  fabric clock (same as IOD RX_CLK)
//   arst                     asynchronous active-high reset
//   train_start              single-cycle start request (IDLE/DONE/ERR only)
//   rx_data[7:0]             deserialized BCLK pattern
//   delay_line_out_of_range  IOD range flag, checked at every evaluation
//   delay_line_load          pulse: reload base delay (tap 0)
//   delay_line_move          pulse: step delay by one tap
//   delay_line_direction     1 = increment, 0 = decrement (held between moves)
//   eye_monitor_clear_flags  pulsed with every load/move
//   train_busy               training in progress
//   train_done, train_err    sticky status, cleared by the next accepted start
//   tap_count[7:0]           current tap relative to base
//   eye_left, eye_right      first/last stable tap of the detected eye
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | load pulse visible, tap_count = 0
// SETTLE | wait SETTLE_CYCLES after a load/move
// SAMPLE | capture SAMPLE_COUNT words, track whether they all match
// EVAL   | classify the tap and advance the search phase
// STEP   | increment move pulse visible
// CENTER | walk back to the eye centre, settle gap between moves
// DONE   | eye found and centred
// ERR    | training failed, tap frozen
module bclk_training_ctrl #(
  parameter int NUM_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 4,
  parameter int MIN_EYE       = 4
) (
  input  logic       fab_clk,
  input  logic       arst,
  input  logic       train_start,
  input  logic [7:0] rx_data,
  input  logic       delay_line_out_of_range,
  output logic       delay_line_load,
  output logic       delay_line_move,
  output logic       delay_line_direction,
  output logic       eye_monitor_clear_flags,
  output logic       train_busy,
  output logic       train_done,
  output logic       train_err,
  output logic [7:0] tap_count,
  output logic [7:0] eye_left,
  output logic [7:0] eye_right
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_CENTER, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    P_SEEK_REF, P_SEEK_E1, P_SEEK_L, P_SEEK_E2
  } phase_t;

  localparam logic [7:0]  LAST_TAP    = 8'(NUM_TAPS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SETTLE_GAP  = 16'(SETTLE_CYCLES);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_COUNT - 1);
  localparam logic [8:0]  MIN_WIDTH   = 9'(MIN_EYE);

  state_t      state;
  phase_t      phase;
  logic [15:0] cnt;
  logic [7:0]  pat;
  logic [7:0]  ref_pat;
  logic [7:0]  new_pat;
  logic        stable;
  logic [7:0]  target;

  // Eye end is evaluated at the first tap past the eye, so the right edge
  // is one below the current tap and the width is simply tap - left.
  logic       eye_end;
  logic [7:0] right_tap;
  logic [8:0] eye_width;
  logic [8:0] eye_sum;

  assign eye_end   = !stable || (pat != new_pat);
  assign right_tap = tap_count - 8'd1;
  assign eye_width = {1'b0, tap_count} - {1'b0, eye_left};
  assign eye_sum   = {1'b0, eye_left} + {1'b0, right_tap};

  always_ff @(posedge fab_clk or posedge arst) begin
    if (arst) begin
      state                   <= S_IDLE;
      phase                   <= P_SEEK_REF;
      cnt                     <= '0;
      pat                     <= '0;
      ref_pat                 <= '0;
      new_pat                 <= '0;
      stable                  <= 1'b0;
      target                  <= '0;
      delay_line_load         <= 1'b0;
      delay_line_move         <= 1'b0;
      delay_line_direction    <= 1'b0;
      eye_monitor_clear_flags <= 1'b0;
      train_busy              <= 1'b0;
      train_done              <= 1'b0;
      train_err               <= 1'b0;
      tap_count               <= '0;
      eye_left                <= '0;
      eye_right               <= '0;
    end else begin
      delay_line_load         <= 1'b0;
      delay_line_move         <= 1'b0;
      eye_monitor_clear_flags <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (train_start) begin
            state                   <= S_LOAD;
            phase                   <= P_SEEK_REF;
            delay_line_load         <= 1'b1;
            eye_monitor_clear_flags <= 1'b1;
            tap_count               <= '0;
            train_busy              <= 1'b1;
            train_done              <= 1'b0;
            train_err               <= 1'b0;
            eye_left                <= '0;
            eye_right               <= '0;
          end
        end
        S_LOAD, S_STEP: begin
          state <= S_SETTLE;
          cnt   <= SETTLE_LAST;
        end
        S_SETTLE: begin
          if (cnt == 16'd0) begin
            state <= S_SAMPLE;
            cnt   <= SAMPLE_LAST;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_SAMPLE: begin
          if (cnt == SAMPLE_LAST) begin
            pat    <= rx_data;
            stable <= 1'b1;
          end else if (rx_data != pat) begin
            stable <= 1'b0;
          end
          if (cnt == 16'd0) state <= S_EVAL;
          else              cnt   <= cnt - 16'd1;
        end
        S_EVAL: begin
          if (delay_line_out_of_range) begin
            state      <= S_ERR;
            train_err  <= 1'b1;
            train_busy <= 1'b0;
          end else if (phase == P_SEEK_E2 && eye_end) begin
            eye_right <= right_tap;
            if (eye_width < MIN_WIDTH) begin
              state      <= S_ERR;
              train_err  <= 1'b1;
              train_busy <= 1'b0;
            end else begin
              target <= eye_sum[8:1];
              state  <= S_CENTER;
              cnt    <= '0;
            end
          end else begin
            case (phase)
              P_SEEK_REF: if (stable) begin
                ref_pat <= pat;
                phase   <= P_SEEK_E1;
              end
              P_SEEK_E1: if (!stable || pat != ref_pat) phase <= P_SEEK_L;
              P_SEEK_L: if (stable) begin
                new_pat  <= pat;
                eye_left <= tap_count;
                phase    <= P_SEEK_E2;
              end
              default: ;
            endcase
            if (tap_count == LAST_TAP) begin
              state      <= S_ERR;
              train_err  <= 1'b1;
              train_busy <= 1'b0;
            end else begin
              state                   <= S_STEP;
              delay_line_move         <= 1'b1;
              delay_line_direction    <= 1'b1;
              eye_monitor_clear_flags <= 1'b1;
              tap_count               <= tap_count + 8'd1;
            end
          end
        end
        S_CENTER: begin
          // cnt holds the remaining settle gap after each decrement move.
          if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (tap_count == target) begin
            state      <= S_DONE;
            train_done <= 1'b1;
            train_busy <= 1'b0;
          end else begin
            delay_line_move         <= 1'b1;
            delay_line_direction    <= 1'b0;
            eye_monitor_clear_flags <= 1'b1;
            tap_count               <= tap_count - 8'd1;
            cnt                     <= SETTLE_GAP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bclk_training_ctrl.md
# bclk_training_ctrl

Fabric-side controller for the DDR3 BCLK training lane. It consumes the deserialized 8-bit BCLK pattern from the BCLK_TRAINING IOD and drives that IOD's dynamic delay-line controls. It sweeps the input delay one tap at a time and locates the stable data eye between two pattern transitions. It then parks the delay line at the eye centre and reports done or error to the DDR PHY training sequencer.

## Interface

Parameters:
- NUM_TAPS, 128: delay-line taps available; must be ≤ 256.
- SETTLE_CYCLES, 8: FAB_CLK cycles waited after every load/move before sampling; ≥ 1.
- SAMPLE_COUNT, 4: consecutive RX_DATA samples that must all be equal for a tap to count as stable; ≥ 2.
- MIN_EYE, 4: minimum stable eye width in taps; a narrower eye is an error.

Ports:
- FAB_CLK  in  1  fabric clock, same clock as the IOD RX_CLK.
- ARST  in  1  asynchronous, active-high reset.
- TRAIN_START  in  1  single-cycle start request; honoured only in IDLE, DONE or ERR.
- RX_DATA  in  8  deserialized BCLK pattern from the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line range flag.
- DELAY_LINE_LOAD  out  1  one-cycle pulse that reloads the IOD base delay (tap 0).
- DELAY_LINE_MOVE  out  1  one-cycle pulse that steps the delay by one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid in every MOVE cycle.
- EYE_MONITOR_CLEAR_FLAGS  out  1  pulsed together with every LOAD and MOVE.
- TRAIN_BUSY  out  1  high from START acceptance until DONE or ERR.
- TRAIN_DONE  out  1  sticky; cleared by the next accepted START.
- TRAIN_ERR  out  1  sticky; cleared by the next accepted START.
- TAP_COUNT  out  8  current tap relative to base.
- EYE_LEFT, EYE_RIGHT  out  8 each  first and last stable tap of the eye found.

## Operation

States are IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, CENTER, DONE and ERR.

- IDLE/DONE/ERR + TRAIN_START → LOAD. On accepting START, clear DONE/ERR/EYE_*, set BUSY and reset the phase to SEEK_REF.
- LOAD (1 cycle): LOAD=1, CLEAR_FLAGS=1, TAP_COUNT←0. Then → SETTLE.
- SETTLE: count SETTLE_CYCLES, then → SAMPLE.
- SAMPLE: capture SAMPLE_COUNT words. The tap is stable only if all the words are equal; the captured pattern is the first word. Then → EVAL.
- EVAL (1 cycle). Check first: if OUT_OF_RANGE=1 → ERR. Then act by phase:
  - SEEK_REF: on a stable tap, REF←pattern and phase becomes SEEK_E1.
  - SEEK_E1: an unstable tap, or a stable tap with pattern≠REF, moves phase to SEEK_L.
  - SEEK_L: on a stable tap, NEW←pattern, EYE_LEFT←TAP_COUNT, and phase becomes SEEK_E2.
  - SEEK_E2: an unstable tap, or a stable tap with pattern≠NEW, ends the eye: EYE_RIGHT←TAP_COUNT−1.
    - If EYE_RIGHT−EYE_LEFT+1 < MIN_EYE → ERR.
    - Otherwise compute target = (EYE_LEFT+EYE_RIGHT)>>1 with a 9-bit sum and → CENTER.
  - In every other case: if TAP_COUNT = NUM_TAPS−1 → ERR, else → STEP.
- STEP (1 cycle): MOVE=1, DIRECTION=1, CLEAR_FLAGS=1, TAP_COUNT+1. Then → SETTLE.
- CENTER: one cycle per step with MOVE=1, DIRECTION=0, CLEAR_FLAGS=1, TAP_COUNT−1. MOVE cycles are separated by SETTLE_CYCLES idle cycles. When TAP_COUNT = target → DONE. No sampling takes place during CENTER.
- DONE: TRAIN_DONE=1, BUSY=0. ERR: TRAIN_ERR=1, BUSY=0, TAP_COUNT frozen, no further moves.

## Timing

- Reset values: all outputs 0 and state IDLE. DIRECTION resets to 0. ARST takes effect immediately, including mid-sweep or mid-centre; no recovery pulse is issued.
- All outputs are registered. Delay-line controls change only on FAB_CLK rising edges.
- START accepted in cycle n → LOAD=1 in cycle n+1.
- Per-tap cost is 1 (LOAD/STEP) + SETTLE_CYCLES + SAMPLE_COUNT + 1 (EVAL) cycles.
- TRAIN_START while BUSY is ignored. START simultaneous with ARST: reset wins.
- DIRECTION is driven in the same cycle as MOVE and holds its last value otherwise.
- A MOVE is never issued in the cycle in which LOAD is asserted.
- TAP_COUNT never wraps: it never exceeds NUM_TAPS−1 and never drops below 0.

## Test plan

- Nominal eye. RX model: 0x55 on taps 0–19, unstable on 20–23, 0xAA on 24–59, unstable from 60. Required: EYE_LEFT=24, EYE_RIGHT=59, 19 MOVE pulses with DIRECTION=0, final TAP_COUNT=41, DONE=1, ERR=0.
- No transition. Constant 0x55 on every tap. Required: ERR=1 at TAP_COUNT=127, exactly 127 increment MOVEs, DONE=0.
- OUT_OF_RANGE asserted while at tap 50. Required: ERR at that tap's EVAL and no MOVE afterwards.
- Narrow eye. 0xAA stable only on taps 24–26 with MIN_EYE=4. Required: ERR=1, EYE_LEFT=24, EYE_RIGHT=26, no CENTER moves.
- Glitch. At tap 10, one of the four samples differs while the surrounding taps are stable 0x55. Required: tap 10 is treated as the first transition (E1), so EYE_LEFT is the first later stable tap.
- ARST at tap 30, then a new START. Required: all outputs go to 0 immediately, LOAD pulses one cycle after START, and the sweep restarts from tap 0. A START pulsed mid-sweep is ignored.
